aud_adc_rx: RTL and testbench
=============================

Name: aud_adc_rx

Overview:
- Audio codec ADC capture stage. Deserialises the codec's I2S ADC stream on the AUD_ADCDAT pin.
- Bit clock and LR clock come from the existing audio DAC block; they are sampled as plain inputs in the audio control clock domain.
- Each complete stereo frame is pushed into a small FIFO. Downstream consumers (loopback, level meter, recorder) pop frames with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 16, bits per channel word, MSB first.
- FIFO_DEPTH, 4, stereo frames buffered; power of 2, at least 2.
- LW, clog2(FIFO_DEPTH+1), width of the level output.

Ports:
- iCLK  in  1  audio control clock (18.4 MHz); the only clock.
- iRST_N  in  1  asynchronous active-low reset.
- iAUD_BCK  in  1  codec bit clock, sampled as data.
- iAUD_LRCK  in  1  ADC LR clock; 0 = left, 1 = right.
- iAUD_ADCDAT  in  1  serial ADC data.
- iREADY  in  1  consumer accepts the head frame.
- iCLR_ERR  in  1  single-cycle pulse; clears the sticky flags.
- oL_DATA  out  DATA_WIDTH  left sample of the head frame.
- oR_DATA  out  DATA_WIDTH  right sample of the head frame.
- oVALID  out  1  FIFO not empty.
- oLEVEL  out  LW  FIFO occupancy.
- oOVERFLOW  out  1  sticky: a frame was dropped because the FIFO was full.
- oFRAME_ERR  out  1  sticky: a slot was shorter than DATA_WIDTH+1 bit-clocks.

Behaviour:
- Reset values:
  - oL_DATA, oR_DATA, oVALID, oLEVEL, oOVERFLOW, oFRAME_ERR all 0.
  - FIFO empty; FSM in WAIT_SYNC; bit counter 0; shift register 0.
- Input conditioning:
  - iAUD_BCK, iAUD_LRCK and iAUD_ADCDAT each pass through a 2-flop synchroniser.
  - A BCK rise is the synchronised BCK at 1 this cycle and 0 the previous cycle.
  - BCK high and low phases must each be at least 2 iCLK cycles; behaviour is unspecified otherwise.
  - All capture logic advances only on a BCK-rise cycle.
- Slot tracking, on each BCK rise:
  - Sample LRCK. If it differs from the LRCK sampled at the previous rise, this rise is the I2S delay bit: no data is shifted, the bit counter is cleared, and the current channel becomes the new LRCK.
  - Otherwise, if bit counter < DATA_WIDTH: shift in DAT (MSB first) and increment the counter.
  - When the counter reaches DATA_WIDTH, the word is latched into the left or right holding register and the channel's done flag is set.
  - Bits beyond DATA_WIDTH in a slot are ignored.
- FSM:
  - WAIT_SYNC: ignore everything until the first LRCK 1->0 transition (start of a left slot), then go to LEFT. No partial frame is ever captured after reset.
  - LEFT: capture the left word. The next LRCK edge goes to RIGHT. If that edge arrives with left not done, set oFRAME_ERR, discard the word, and go to RIGHT with the frame marked bad.
  - RIGHT: capture the right word. The next LRCK edge (1->0) goes to LEFT. Frame push occurs at the moment the right word completes (counter hits DATA_WIDTH), provided the frame is not marked bad. A short right slot sets oFRAME_ERR and skips the push. The bad mark clears on entry to LEFT.
- Latency: the frame appears on oVALID 1 iCLK after the BCK-rise cycle that completes the right word, plus 2 synchroniser cycles from the pin.
- FIFO:
  - oL_DATA/oR_DATA show the head entry combinationally from registered storage (first-word fall-through).
  - Pop when oVALID && iREADY.
  - oLEVEL = pushes − pops.
  - Push while full and no pop: the frame is dropped, FIFO unchanged, oOVERFLOW set.
  - Push and pop in the same cycle while full: both take effect, oLEVEL unchanged, no overflow.
  - Push and pop in the same cycle while empty: only the push takes effect (pop requires oVALID).
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags:
  - Set conditions have priority over iCLR_ERR in the same cycle.
  - iCLR_ERR affects nothing else.
- Reset mid-frame:
  - Immediately returns to the reset state.
  - The FIFO contents are lost.
  - Capture resumes only after the next LRCK 1->0 transition.

Test Plan:
- BCK = iCLK/8, 32 BCK per LR half. Send L=16'hA5C3, R=16'h0F0F after reset, starting mid right slot.
  -> The first partial frame is ignored. First pop gives oL=A5C3, oR=0F0F; oLEVEL goes 0->1->0.
- 6 consecutive frames L=n, R=~n (n = 1..6), iREADY held 0.
  -> oLEVEL saturates at 4 and oOVERFLOW=1. Then pop with iREADY=1: outputs are frames 1..4 in order, and frames 5 and 6 are absent.
- FIFO full with iREADY=1 during the cycle frame 5 pushes.
  -> oLEVEL stays at 4 and oOVERFLOW stays 0. The pop returns frame 1, and frame 5 is retained at the tail.
- Left slot cut to 10 BCK rises (LRCK toggles early), followed by valid frame L=1234, R=5678.
  -> oFRAME_ERR=1 and the bad frame is not pushed. The next frame pops as 1234/5678. iCLR_ERR pulse -> oFRAME_ERR=0.
- iRST_N asserted for 3 iCLK mid right-word with oLEVEL=2.
  -> All outputs go to 0 asynchronously. After release, no push occurs until the next left slot starts; the next complete frame gives oLEVEL=1.
- iCLR_ERR pulsed in the same cycle as an overflow drop.
  -> oOVERFLOW remains 1.

Source files
------------

// File: rtl/aud_adc_rx_if.sv
// Stereo frame stream leaving the ADC capture stage: head frame, valid/ready, occupancy.
// The master drives the frame and occupancy; the slave returns ready.
interface aud_adc_rx_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LW         = 3
) ();
  logic [DATA_WIDTH-1:0] oL_DATA;
  logic [DATA_WIDTH-1:0] oR_DATA;
  logic                  oVALID;
  logic                  iREADY;
  logic [LW-1:0]         oLEVEL;

  modport master (
    output oL_DATA,
    output oR_DATA,
    output oVALID,
    output oLEVEL,
    input  iREADY
  );

  modport slave (
    input  oL_DATA,
    input  oR_DATA,
    input  oVALID,
    input  oLEVEL,
    output iREADY
  );
endinterface

// File: rtl/aud_adc_rx.sv
// I2S ADC capture: synchronises BCK/LRCK/DAT into iCLK, deserialises left/right
// words and queues complete stereo frames in a first-word fall-through FIFO.
module aud_adc_rx #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic           iCLK,
  input  logic           iRST_N,
  input  logic           iAUD_BCK,
  input  logic           iAUD_LRCK,
  input  logic           iAUD_ADCDAT,
  input  logic           iCLR_ERR,
  output logic           oOVERFLOW,
  output logic           oFRAME_ERR,
  aud_adc_rx_if.master   frm
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } state_t;

  logic [1:0]            bck_sync_r;
  logic [1:0]            lrck_sync_r;
  logic [1:0]            dat_sync_r;
  logic                  bck_prev_r;
  logic                  lrck_last_r;

  state_t                state_r;
  logic [CW-1:0]         bit_cnt_r;
  logic [DATA_WIDTH-2:0] shift_r;
  logic                  done_r;
  logic                  bad_r;
  logic [DATA_WIDTH-1:0] left_hold_r;

  logic [DATA_WIDTH-1:0] l_mem_r [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [LW-1:0]         level_r;
  logic                  valid_r;
  logic                  ovf_r;
  logic                  ferr_r;

  logic                  rise_s;
  logic                  lrck_s;
  logic                  lr_edge_s;
  logic                  shift_en_s;
  logic                  word_done_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic                  push_s;
  logic                  ferr_set_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  wr_s;
  logic                  ovf_set_s;
  logic [LW-1:0]         level_nxt_s;

  // Two-flop synchronisers for the codec pins plus the BCK history for edge detection.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bck_sync_r  <= 2'b00;
      lrck_sync_r <= 2'b00;
      dat_sync_r  <= 2'b00;
      bck_prev_r  <= 1'b0;
    end else begin
      bck_sync_r  <= {bck_sync_r[0], iAUD_BCK};
      lrck_sync_r <= {lrck_sync_r[0], iAUD_LRCK};
      dat_sync_r  <= {dat_sync_r[0], iAUD_ADCDAT};
      bck_prev_r  <= bck_sync_r[1];
    end
  end

  // Per-rise decode: slot edges, shifting, word completion, push and slot-error strobes.
  always_comb begin
    rise_s      = bck_sync_r[1] & ~bck_prev_r;
    lrck_s      = lrck_sync_r[1];
    lr_edge_s   = rise_s & (lrck_s != lrck_last_r);
    shift_en_s  = rise_s & ~lr_edge_s & (bit_cnt_r < CNT_FULL);
    word_s      = {shift_r, dat_sync_r[1]};
    word_done_s = shift_en_s & (bit_cnt_r == CNT_LAST);
    push_s      = 1'b0;
    ferr_set_s  = 1'b0;
    if (word_done_s && (state_r == RIGHT) && !bad_r) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    // A slot ending before its word completed is an error only once we are in sync.
    if (lr_edge_s && !done_r &&
        (((state_r == LEFT) && lrck_s) || ((state_r == RIGHT) && !lrck_s))) begin
      ferr_set_s = 1'b1;
    end else begin
      ferr_set_s = 1'b0;
    end
  end

  // Slot FSM, bit counter, shift register and left holding register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r     <= WAIT_SYNC;
      bit_cnt_r   <= '0;
      shift_r     <= '0;
      done_r      <= 1'b0;
      bad_r       <= 1'b0;
      left_hold_r <= '0;
      lrck_last_r <= 1'b0;
    end else if (rise_s) begin
      lrck_last_r <= lrck_s;
      if (lr_edge_s) begin
        bit_cnt_r <= '0;
        done_r    <= 1'b0;
        case (state_r)
          WAIT_SYNC: begin
            if (!lrck_s) begin
              state_r <= LEFT;
              bad_r   <= 1'b0;
            end else begin
              state_r <= WAIT_SYNC;
            end
          end
          LEFT: begin
            if (lrck_s) begin
              state_r <= RIGHT;
              bad_r   <= ~done_r;
            end else begin
              state_r <= WAIT_SYNC;
            end
          end
          RIGHT: begin
            if (!lrck_s) begin
              state_r <= LEFT;
              bad_r   <= 1'b0;
            end else begin
              state_r <= WAIT_SYNC;
            end
          end
          default: begin
            state_r <= WAIT_SYNC;
          end
        endcase
      end else if (shift_en_s) begin
        shift_r   <= word_s[DATA_WIDTH-2:0];
        bit_cnt_r <= bit_cnt_r + CW'(1);
        if (bit_cnt_r == CNT_LAST) begin
          done_r <= 1'b1;
          if (state_r == LEFT) begin
            left_hold_r <= word_s;
          end
        end
      end
    end
  end

  // FIFO control: a push into a full FIFO survives only when a pop frees a slot that cycle.
  always_comb begin
    pop_s     = valid_r & frm.iREADY;
    full_s    = (level_r == LVL_FULL);
    wr_s      = push_s & (~full_s | pop_s);
    ovf_set_s = push_s & full_s & ~pop_s;
    case ({wr_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Frame storage, pointers and occupancy.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        l_mem_r[i] <= '0;
        r_mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (wr_s) begin
        l_mem_r[wr_ptr_r] <= left_hold_r;
        r_mem_r[wr_ptr_r] <= word_s;
        wr_ptr_r          <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      level_r <= level_nxt_s;
      valid_r <= (level_nxt_s != '0);
    end
  end

  // Sticky error flags; a new set event wins over a clear in the same cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      ovf_r  <= 1'b0;
      ferr_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (iCLR_ERR) begin
        ovf_r <= 1'b0;
      end
      if (ferr_set_s) begin
        ferr_r <= 1'b1;
      end else if (iCLR_ERR) begin
        ferr_r <= 1'b0;
      end
    end
  end

  // Head frame is read straight from storage.
  always_comb begin
    frm.oL_DATA = l_mem_r[rd_ptr_r];
    frm.oR_DATA = r_mem_r[rd_ptr_r];
    frm.oVALID  = valid_r;
    frm.oLEVEL  = level_r;
    oOVERFLOW   = ovf_r;
    oFRAME_ERR  = ferr_r;
  end

endmodule

// File: tb/tb_aud_adc_rx.sv
// Bench for aud_adc_rx: drives I2S slots at BCK = iCLK/8 and compares against a
// slot-level reference model (sync/bad-frame rules plus a frame queue).
module tb_aud_adc_rx;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic aud_bck = 1'b0;
  logic aud_lrck = 1'b1;
  logic aud_dat = 1'b0;
  logic clr_err = 1'b0;
  logic overflow;
  logic frame_err;

  aud_adc_rx_if #(.DATA_WIDTH(DW), .LW(LW)) frm_if ();

  aud_adc_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LW(LW)) dut (
    .iCLK        (clk),
    .iRST_N      (rst_n),
    .iAUD_BCK    (aud_bck),
    .iAUD_LRCK   (aud_lrck),
    .iAUD_ADCDAT (aud_dat),
    .iCLR_ERR    (clr_err),
    .oOVERFLOW   (overflow),
    .oFRAME_ERR  (frame_err),
    .frm         (frm_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_q[$];
  bit          m_ovf, m_ferr, m_synced, m_bad, m_prev_lr;
  int          m_prev_len;
  logic [15:0] m_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One BCK period; act 1 pulses ready, act 2 pulses clear, in the cycle a frame completes.
  task automatic bck_cycle(input logic lr, input logic d, input int act, input logic [31:0] exp_head);
    aud_bck = 1'b0; aud_lrck = lr; aud_dat = d;
    repeat (4) @(negedge clk);
    aud_bck = 1'b1;
    repeat (2) @(negedge clk);
    if (act == 1) begin
      chk("collide_head", {frm_if.oL_DATA, frm_if.oR_DATA}, exp_head);
      frm_if.iREADY = 1'b1;
    end else if (act == 2) begin
      clr_err = 1'b1;
    end
    @(negedge clk);
    frm_if.iREADY = 1'b0;
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_slot(input logic lr, input logic [15:0] w, input int len, input int act);
    logic [31:0] head;
    logic        d;
    if (lr != m_prev_lr) begin
      if (m_synced && m_prev_len < DW + 1) m_ferr = 1'b1;
      if (lr == 1'b0) begin
        m_synced = 1'b1;
        m_bad    = 1'b0;
      end else if (m_synced) begin
        m_bad = (m_prev_len < DW + 1);
      end
      m_prev_len = len;
    end else begin
      m_prev_len += len;
    end
    m_prev_lr = lr;
    for (int i = 0; i < len; i++) begin
      head = 32'h0;
      if (i >= 1 && i <= DW) d = w[DW - i];
      else d = 1'($urandom_range(0, 1));
      if (i == DW && m_synced) begin
        if (lr == 1'b0) begin
          m_left = w;
        end else if (!m_bad) begin
          if (act == 1 && m_q.size() > 0) begin
            head = m_q.pop_front();
            m_q.push_back({m_left, w});
          end else if (m_q.size() < DEPTH) begin
            m_q.push_back({m_left, w});
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
      bck_cycle(lr, d, (i == DW) ? act : 0, head);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input int llen, input int rlen, input int act);
    send_slot(1'b0, l, llen, 0);
    send_slot(1'b1, r, rlen, act);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_level"}, 32'(frm_if.oLEVEL), 32'(m_q.size()));
    chk({tag, "_valid"}, 32'(frm_if.oVALID), 32'(m_q.size() != 0));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
  endtask

  task automatic drain(input string tag);
    while (m_q.size() > 0) begin
      chk({tag, "_valid"}, 32'(frm_if.oVALID), 32'h1);
      chk({tag, "_data"}, {frm_if.oL_DATA, frm_if.oR_DATA}, m_q[0]);
      frm_if.iREADY = 1'b1;
      @(negedge clk);
      frm_if.iREADY = 1'b0;
      void'(m_q.pop_front());
      chk({tag, "_lvl"}, 32'(frm_if.oLEVEL), 32'(m_q.size()));
    end
    chk({tag, "_empty"}, 32'(frm_if.oVALID), 32'h0);
  endtask

  task automatic clear_flags(input string tag);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    check_state(tag);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0; m_ferr = 1'b0; m_synced = 1'b0; m_bad = 1'b0;
    m_prev_lr = 1'b0; m_prev_len = 0; m_left = 16'h0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_l"}, 32'(frm_if.oL_DATA), 32'h0);
    chk({tag, "_r"}, 32'(frm_if.oR_DATA), 32'h0);
    check_state(tag);
  endtask

  initial begin
    logic [15:0] nn, a, b;
    int          ll, rl;
    frm_if.iREADY = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // partial right slot after reset is ignored, then one clean frame
    send_slot(1'b1, 16'h0F0F, 12, 0);
    check_state("partial");
    send_frame(16'hA5C3, 16'h0F0F, 32, 32, 0);
    check_state("first");
    drain("first");

    // six frames with no consumer: four kept, two dropped
    for (int n = 1; n <= 6; n++) begin
      nn = 16'(n);
      send_frame(nn, ~nn, 32, 32, 0);
    end
    check_state("ovf6");
    drain("ovf6");
    clear_flags("ovf6_clr");

    // full FIFO, pop coincides with the fifth push
    for (int n = 0; n < 5; n++) begin
      a = 16'($urandom); b = 16'($urandom);
      send_frame(a, b, 32, 32, (n == 4) ? 1 : 0);
    end
    check_state("collide");
    drain("collide");

    // short left slot makes a bad frame that must not be queued
    send_slot(1'b0, 16'hFFFF, 10, 0);
    send_slot(1'b1, 16'hBEEF, 32, 0);
    send_frame(16'h1234, 16'h5678, 32, 32, 0);
    check_state("short");
    drain("short");
    clear_flags("short_clr");

    // reset in the middle of a right word with two frames queued
    send_frame(16'($urandom), 16'($urandom), 32, 32, 0);
    send_frame(16'($urandom), 16'($urandom), 32, 32, 0);
    check_state("pre_rst");
    send_slot(1'b0, 16'h1111, 32, 0);
    send_slot(1'b1, 16'h2222, 8, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_slot(1'b1, 16'h3333, 24, 0);
    check_state("post_rst");
    send_frame(16'hCAFE, 16'hF00D, 32, 32, 0);
    check_state("post_rst_frame");
    drain("post_rst");

    // clear pulse in the same cycle as an overflow drop
    for (int n = 0; n < 5; n++) begin
      a = 16'($urandom); b = 16'($urandom);
      send_frame(a, b, 32, 32, (n == 4) ? 2 : 0);
    end
    check_state("clr_vs_ovf");
    drain("clr_vs_ovf");
    clear_flags("clr_vs_ovf_clr");

    // randomized frames with occasional short slots and random drains
    for (int k = 0; k < 40; k++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      ll = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 16) : $urandom_range(17, 32);
      rl = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 16) : $urandom_range(17, 32);
      send_frame(a, b, ll, rl, 0);
      check_state("rand");
      if ($urandom_range(0, 3) == 0) drain("rand");
    end
    drain("rand_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
